// File: rtl/tc_operand_stager_pkg.sv
// Shared constants and the assembled-tile type for the tensor-core operand stager.
package tc_pkg;

    localparam int TC_BEATS_FULL = 12;
    localparam int TC_BEATS_NOC  = 8;
    localparam int TC_BEAT_W     = 64;
    localparam int TC_OPND_W     = 256;
    localparam int TC_BIDX_W     = 4;

    typedef struct packed {
        logic [TC_OPND_W-1:0] a;
        logic [TC_OPND_W-1:0] b;
        logic [TC_OPND_W-1:0] c;
        logic                 mode;
    } tc_tile_t;

endpackage

// File: rtl/tc_operand_stager_if.sv
// Beat stream from the operand source into the stager.
interface tc_operand_stager_if;

    logic                        s_valid;
    logic                        s_ready;
    logic [tc_pkg::TC_BEAT_W-1:0] s_data;
    logic                        s_mode;
    logic                        s_czero;

    modport master (output s_valid, output s_data, output s_mode, output s_czero, input s_ready);
    modport slave  (input s_valid, input s_data, input s_mode, input s_czero, output s_ready);

endinterface

// File: rtl/tc_operand_stager_tile_buf.sv
// One tile register: beat-indexed row writes and a full flag. tile_nxt exposes the
// contents including the beat being written this cycle, so the last beat can issue at once.
module tc_tile_buf
    import tc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [TC_BIDX_W-1:0] wr_idx,
    input  logic [TC_BEAT_W-1:0] wr_data,
    input  logic                 wr_mode,
    input  logic                 wr_czero,
    input  logic                 set_full,
    input  logic                 clr_full,
    output logic                 full,
    output tc_tile_t             tile_nxt
);

    tc_tile_t tile_q;

    always_comb begin
        tile_nxt = tile_q;
        if (wr_en) begin
            case (wr_idx[3:2])
                2'd0:    tile_nxt.a[wr_idx[1:0]*TC_BEAT_W +: TC_BEAT_W] = wr_data;
                2'd1:    tile_nxt.b[wr_idx[1:0]*TC_BEAT_W +: TC_BEAT_W] = wr_data;
                2'd2:    tile_nxt.c[wr_idx[1:0]*TC_BEAT_W +: TC_BEAT_W] = wr_data;
                default: ;
            endcase
            // Beat 0 carries the tile attributes; a zero-C tile never writes C rows.
            if (wr_idx == '0) begin
                tile_nxt.mode = wr_mode;
                if (wr_czero)
                    tile_nxt.c = '0;
            end
        end
    end

    always_ff @(posedge clk)
        tile_q <= tile_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            full <= 1'b0;
        else if (clr_full)
            full <= 1'b0;
        else if (set_full)
            full <= 1'b1;
    end

endmodule

// File: rtl/tc_operand_stager.sv
// Ping-pong operand stager for the 4x4x8 FP8 tensor core with credit-based issue.
// Optional macro TC_STAGER_CZERO_EN enables 8-beat tiles with an implicit all-zero C.
module tc_operand_stager
    import tc_pkg::*;
#(
    parameter int MAX_INFLIGHT = 8,
    parameter int INFLIGHT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    tc_operand_stager_if.slave    s,
    output logic                  tc_in_valid,
    output logic                  tc_e5m2mode,
    output logic [TC_OPND_W-1:0]  tc_a,
    output logic [TC_OPND_W-1:0]  tc_b,
    output logic [TC_OPND_W-1:0]  tc_c,
    input  logic                  tc_out_valid,
    output logic [INFLIGHT_W-1:0] inflight,
    output logic                  busy,
    output logic                  err
);

    logic [1:0]           full;
    tc_tile_t             tile_nxt [2];
    tc_tile_t             head;
    tc_tile_t             opnd_p1;
    logic                 vld_p1;
    logic                 wr_sel, rd_sel;
    logic [TC_BIDX_W-1:0] beat_cnt, last_idx;
    logic                 tile_cz, cur_cz, cz_in;
    logic                 accept, last_acc, head_rdy, issue, ret_ok;

`ifdef TC_STAGER_CZERO_EN
    assign cz_in = s.s_czero;
`else
    logic unused_czero;
    assign unused_czero = s.s_czero;
    assign cz_in        = 1'b0;
`endif

    assign s.s_ready = ~(full[0] & full[1]);
    assign accept    = s.s_valid & s.s_ready;
    assign cur_cz    = (beat_cnt == '0) ? cz_in : tile_cz;
    assign last_idx  = cur_cz ? TC_BIDX_W'(TC_BEATS_NOC - 1) : TC_BIDX_W'(TC_BEATS_FULL - 1);
    assign last_acc  = accept && (beat_cnt == last_idx);

    for (genvar i = 0; i < 2; i++) begin : g_buf
        tc_tile_buf u_buf (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (accept && (wr_sel == 1'(i))),
            .wr_idx   (beat_cnt),
            .wr_data  (s.s_data),
            .wr_mode  (s.s_mode),
            .wr_czero (cz_in),
            .set_full (last_acc && (wr_sel == 1'(i))),
            .clr_full (issue && (rd_sel == 1'(i))),
            .full     (full[i]),
            .tile_nxt (tile_nxt[i])
        );
    end

    // Head is either a stored tile or the tile completing right now in the same buffer.
    assign head     = tile_nxt[rd_sel];
    assign head_rdy = full[rd_sel] | (last_acc & (wr_sel == rd_sel));
    assign issue    = head_rdy
                    && (inflight < INFLIGHT_W'(MAX_INFLIGHT))
                    && ((head.mode == tc_e5m2mode) || (inflight == '0));
    assign ret_ok   = tc_out_valid && (inflight != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            tile_cz  <= 1'b0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= last_acc ? '0 : beat_cnt + 1'b1;
                if (beat_cnt == '0)
                    tile_cz <= cz_in;
            end
            if (last_acc)
                wr_sel <= ~wr_sel;
            if (issue)
                rd_sel <= ~rd_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            case ({issue, ret_ok})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
            if (tc_out_valid && (inflight == '0))
                err <= 1'b1;
        end
    end

    // p1: operands registered on the issue edge and held until the next issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            opnd_p1 <= '0;
        end else begin
            vld_p1 <= issue;
            if (issue)
                opnd_p1 <= head;
        end
    end

    assign tc_in_valid = vld_p1;
    assign tc_e5m2mode = opnd_p1.mode;
    assign tc_a        = opnd_p1.a;
    assign tc_b        = opnd_p1.b;
    assign tc_c        = opnd_p1.c;
    assign busy        = (|full) | (beat_cnt != '0) | (inflight != '0);

endmodule

// File: tb/tb_tc_operand_stager.sv
// Directed-sequence bench with random payloads checked against a tile-queue reference.
module tb_tc_operand_stager;
    import tc_pkg::*;

`ifdef TC_STAGER_CZERO_EN
    localparam bit CZ_EN = 1'b1;
`else
    localparam bit CZ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tc_in_valid, tc_e5m2mode, busy, err;
    logic [255:0] tc_a, tc_b, tc_c;
    logic         tc_out_valid = 1'b0;
    logic [3:0]   inflight;

    int       n_checks = 0;
    int       n_errs   = 0;
    int       issue_cnt = 0;
    int       base;
    tc_tile_t exp_q [$];

    always #5 clk = ~clk;

    tc_operand_stager_if bus ();

    tc_operand_stager #(.MAX_INFLIGHT(8), .INFLIGHT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .s            (bus),
        .tc_in_valid  (tc_in_valid),
        .tc_e5m2mode  (tc_e5m2mode),
        .tc_a         (tc_a),
        .tc_b         (tc_b),
        .tc_c         (tc_c),
        .tc_out_valid (tc_out_valid),
        .inflight     (inflight),
        .busy         (busy),
        .err          (err)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Every issue pulse must carry the oldest queued tile.
    always @(negedge clk) begin : mon
        tc_tile_t e;
        if (rst && tc_in_valid) begin
            issue_cnt++;
            check("issue_has_expected_tile", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tc_a", tc_a, e.a);
                check("tc_b", tc_b, e.b);
                check("tc_c", tc_c, e.c);
                check("tc_e5m2mode", 256'(tc_e5m2mode), 256'(e.mode));
            end
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic m, input logic cz, input bit with_ret);
        int w = 0;
        bus.s_valid  = 1'b1;
        bus.s_data   = d;
        bus.s_mode   = m;
        bus.s_czero  = cz;
        if (with_ret) tc_out_valid = 1'b1;
        @(negedge clk);
        while (!bus.s_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (w == 200) check("s_ready_wait", 256'(bus.s_ready), 256'(1));
        @(posedge clk);
        #1;
        bus.s_valid  = 1'b0;
        bus.s_data   = {$urandom, $urandom};
        bus.s_mode   = 1'($urandom);
        bus.s_czero  = 1'($urandom);
        tc_out_valid = 1'b0;
    endtask

    // Builds the expected operand words directly from the beat order rule.
    task automatic send_tile(input logic m, input logic cz, input bit idx_pat, input bit ret_last);
        logic [63:0] bt [12];
        tc_tile_t    e;
        int          nb;
        nb = (cz && CZ_EN) ? TC_BEATS_NOC : TC_BEATS_FULL;
        for (int k = 0; k < 12; k++)
            bt[k] = idx_pat ? {8{8'(k)}} : {$urandom, $urandom};
        e.a    = {bt[3], bt[2], bt[1], bt[0]};
        e.b    = {bt[7], bt[6], bt[5], bt[4]};
        e.c    = (nb == TC_BEATS_NOC) ? 256'd0 : {bt[11], bt[10], bt[9], bt[8]};
        e.mode = m;
        exp_q.push_back(e);
        for (int k = 0; k < nb; k++)
            drive_beat(bt[k], (k == 0) ? m : 1'($urandom), (k == 0) ? cz : 1'($urandom),
                       ret_last && (k == nb - 1));
    endtask

    task automatic send_partial(input int n);
        for (int k = 0; k < n; k++)
            drive_beat({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ret();
        tc_out_valid = 1'b1;
        @(posedge clk);
        #1;
        tc_out_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_mode  = 1'b0;
        bus.s_czero = 1'b0;
        cycles(3);
        check("rst_in_valid", 256'(tc_in_valid), 256'(0));
        check("rst_tc_a", tc_a, 256'd0);
        check("rst_tc_c", tc_c, 256'd0);
        check("rst_inflight", 256'(inflight), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_s_ready", 256'(bus.s_ready), 256'(1));
        rst = 1'b1;
        cycles(1);

        // Single tile with index pattern
        base = issue_cnt;
        send_tile(1'b0, 1'b0, 1'b1, 1'b0);
        check("single_in_valid", 256'(tc_in_valid), 256'(1));
        check("single_a_row0", 256'(tc_a[63:0]), 256'(64'h0));
        check("single_c_row3", 256'(tc_c[255:192]), 256'(64'h0B0B0B0B0B0B0B0B));
        check("single_inflight", 256'(inflight), 256'(1));
        cycles(1);
        check("single_pulse_once", 256'(tc_in_valid), 256'(0));
        check("single_issue_cnt", 256'(issue_cnt - base), 256'(1));
        ret();
        check("single_drained", 256'(inflight), 256'(0));

        // Credit limit
        base = issue_cnt;
        repeat (10) send_tile(1'b0, 1'b0, 1'b0, 1'b0);
        cycles(3);
        check("credit_issues", 256'(issue_cnt - base), 256'(8));
        check("credit_inflight", 256'(inflight), 256'(8));
        check("credit_s_ready", 256'(bus.s_ready), 256'(0));
        check("credit_busy", 256'(busy), 256'(1));
        ret();
        check("credit_ret_in_valid", 256'(tc_in_valid), 256'(0));
        check("credit_ret_inflight", 256'(inflight), 256'(7));
        cycles(1);
        check("credit_reissue", 256'(tc_in_valid), 256'(1));
        check("credit_refill", 256'(inflight), 256'(8));
        check("credit_s_ready_back", 256'(bus.s_ready), 256'(1));
        g = 0;
        while (inflight != 0 && g < 50) begin
            ret();
            g++;
        end
        cycles(2);
        check("credit_all_issued", 256'(issue_cnt - base), 256'(10));
        check("credit_queue_empty", 256'(exp_q.size()), 256'(0));
        check("credit_err", 256'(err), 256'(0));

        // Mode switch with strict FIFO ordering behind the stall
        base = issue_cnt;
        send_tile(1'b0, 1'b0, 1'b0, 1'b0);
        send_tile(1'b1, 1'b0, 1'b0, 1'b0);
        send_tile(1'b0, 1'b0, 1'b0, 1'b0);
        cycles(4);
        check("mode_stalled", 256'(issue_cnt - base), 256'(1));
        check("mode_level0", 256'(tc_e5m2mode), 256'(0));
        check("mode_both_full", 256'(bus.s_ready), 256'(0));
        ret();
        check("mode_wait_drain", 256'(tc_in_valid), 256'(0));
        cycles(1);
        check("mode_switch_issue", 256'(tc_in_valid), 256'(1));
        check("mode_level1", 256'(tc_e5m2mode), 256'(1));
        cycles(3);
        check("mode_third_held", 256'(issue_cnt - base), 256'(2));
        ret();
        cycles(1);
        check("mode_back_issue", 256'(tc_in_valid), 256'(1));
        check("mode_back_level0", 256'(tc_e5m2mode), 256'(0));
        ret();

        // Simultaneous issue and return, then spurious return
        repeat (3) send_tile(1'b0, 1'b0, 1'b0, 1'b0);
        check("sim_pre_inflight", 256'(inflight), 256'(3));
        send_tile(1'b0, 1'b0, 1'b0, 1'b1);
        check("sim_issue", 256'(tc_in_valid), 256'(1));
        check("sim_inflight", 256'(inflight), 256'(3));
        repeat (3) ret();
        check("sim_drained", 256'(inflight), 256'(0));
        check("sim_no_err", 256'(err), 256'(0));
        ret();
        check("spur_err", 256'(err), 256'(1));
        check("spur_inflight", 256'(inflight), 256'(0));
        cycles(5);
        check("spur_err_sticky", 256'(err), 256'(1));

        // Reset mid-tile
        send_partial(5);
        check("partial_busy", 256'(busy), 256'(1));
        rst = 1'b0;
        #1;
        check("mrst_tc_a", tc_a, 256'd0);
        check("mrst_tc_b", tc_b, 256'd0);
        check("mrst_inflight", 256'(inflight), 256'(0));
        check("mrst_err", 256'(err), 256'(0));
        check("mrst_busy", 256'(busy), 256'(0));
        check("mrst_s_ready", 256'(bus.s_ready), 256'(1));
        cycles(2);
        rst = 1'b1;
        cycles(1);
        send_tile(1'b1, 1'b0, 1'b0, 1'b0);
        check("fresh_issue", 256'(tc_in_valid), 256'(1));
        check("fresh_mode", 256'(tc_e5m2mode), 256'(1));
        check("fresh_inflight", 256'(inflight), 256'(1));
        ret();

`ifdef TC_STAGER_CZERO_EN
        send_tile(1'b0, 1'b1, 1'b0, 1'b0);
        check("czero_issue", 256'(tc_in_valid), 256'(1));
        check("czero_c", tc_c, 256'd0);
        send_tile(1'b0, 1'b0, 1'b0, 1'b0);
        check("czero_next_issue", 256'(tc_in_valid), 256'(1));
        repeat (2) ret();
`endif

        cycles(3);
        check("final_queue_empty", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
